// File: rtl/mem_responder_if.sv
// mem_responder_if: request/grant and read-return bus between the core's
// fetch and data ports and the memory responder.
interface mem_responder_if #(
   parameter int AW = 8,
   parameter int DW = 8
) ();
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic          if_gnt;
   logic          if_rvalid;
   logic [DW-1:0] if_rdata;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic          d_gnt;
   logic          d_rvalid;
   logic [DW-1:0] d_rdata;
   logic          busy;
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, busy
   );
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, busy
   );
endinterface

// File: rtl/mem_responder.sv
// mem_responder: single-port RAM shared by fetch and data ports with fair arbitration
// and fixed-latency read return. MEM_ACCESS_CNT_EN adds saturating per-port grant counters.
module mem_responder #(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int DEPTH      = 256,
   parameter int RD_LATENCY = 1
) (
   input  logic           clk,
   input  logic           rst_n,
   mem_responder_if.slave bus
`ifdef MEM_ACCESS_CNT_EN
   ,
   output logic [15:0]    if_cnt,
   output logic [15:0]    d_cnt
`endif
);
   localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   localparam int L  = RD_LATENCY;
   logic [DW-1:0] mem_q [DEPTH];
   logic          last_d_q, last_d_d;
   logic [L-1:0]  v_q, v_d, p_q, p_d;
   logic [DW-1:0] dat_q [L];
   logic [DW-1:0] dat_d [L];
   logic [DW-1:0] if_hold_q, if_hold_d, d_hold_q, d_hold_d;
   logic          if_gnt, d_gnt, rd_en, in_range, if_rv, d_rv;
   logic [AW-1:0] addr;
   logic [DW-1:0] rd_data;
   // last_d_q = 1 when the data port won the most recent contended cycle
   always_comb begin
      d_gnt     = rst_n & bus.d_req & ~(bus.if_req & last_d_q);
      if_gnt    = rst_n & bus.if_req & ~d_gnt;
      last_d_d  = (bus.if_req & bus.d_req) ? d_gnt : last_d_q;
      addr      = d_gnt ? bus.d_addr : bus.if_addr;
      in_range  = 32'(addr) < DEPTH;
      rd_data   = in_range ? mem_q[addr[IW-1:0]] : '0;
      rd_en     = if_gnt | (d_gnt & ~bus.d_we);
      v_d       = (v_q << 1) | L'(rd_en);
      p_d       = (p_q << 1) | L'(d_gnt);
      dat_d[0]  = rd_data;
      for (int i = 1; i < L; i++) dat_d[i] = dat_q[i-1];
      if_rv     = v_q[L-1] & ~p_q[L-1];
      d_rv      = v_q[L-1] & p_q[L-1];
      if_hold_d = if_rv ? dat_q[L-1] : if_hold_q;
      d_hold_d  = d_rv ? dat_q[L-1] : d_hold_q;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_d_q  <= 1'b0;
         v_q       <= '0;
         p_q       <= '0;
         if_hold_q <= '0;
         d_hold_q  <= '0;
         for (int i = 0; i < L; i++) dat_q[i] <= '0;
      end else begin
         last_d_q  <= last_d_d;
         v_q       <= v_d;
         p_q       <= p_d;
         if_hold_q <= if_hold_d;
         d_hold_q  <= d_hold_d;
         for (int i = 0; i < L; i++) dat_q[i] <= dat_d[i];
      end
   end
   // array contents survive reset
   always_ff @(posedge clk) begin
      if (d_gnt && bus.d_we && in_range) mem_q[addr[IW-1:0]] <= bus.d_wdata;
   end
   assign bus.if_gnt    = if_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.if_rvalid = if_rv;
   assign bus.d_rvalid  = d_rv;
   assign bus.if_rdata  = if_rv ? dat_q[L-1] : if_hold_q;
   assign bus.d_rdata   = d_rv ? dat_q[L-1] : d_hold_q;
   assign bus.busy      = |v_q;
`ifdef MEM_ACCESS_CNT_EN
   logic [15:0] if_cnt_q, if_cnt_d, d_cnt_q, d_cnt_d;
   always_comb begin
      if_cnt_d = if_cnt_q + 16'(if_gnt && if_cnt_q != 16'hFFFF);
      d_cnt_d  = d_cnt_q + 16'(d_gnt && d_cnt_q != 16'hFFFF);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         if_cnt_q <= '0;
         d_cnt_q  <= '0;
      end else begin
         if_cnt_q <= if_cnt_d;
         d_cnt_q  <= d_cnt_d;
      end
   end
   assign if_cnt = if_cnt_q;
   assign d_cnt  = d_cnt_q;
`endif
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed stimulus on two responders (latency 1 / depth 256 and
// latency 3 / depth 128); a monitor checks every read return against a scoreboard.
module tb_mem_responder;
   typedef struct {
      logic [7:0] d;
      int         due;
   } exp_t;
   logic clk = 1'b0;
   logic rst_a_n = 1'b0;
   logic rst_b_n = 1'b0;
   int   cyc = 0;
   int   ntests = 0;
   int   nfail = 0;
   exp_t q [4][$];
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   mem_responder_if #(.AW(8), .DW(8)) a ();
   mem_responder_if #(.AW(8), .DW(8)) b ();
`ifdef MEM_ACCESS_CNT_EN
   logic [15:0] a_if_cnt, a_d_cnt, b_if_cnt, b_d_cnt;
`endif
   mem_responder #(.AW(8), .DW(8), .DEPTH(256), .RD_LATENCY(1)) ua (
      .clk(clk), .rst_n(rst_a_n), .bus(a)
`ifdef MEM_ACCESS_CNT_EN
      , .if_cnt(a_if_cnt), .d_cnt(a_d_cnt)
`endif
   );
   mem_responder #(.AW(8), .DW(8), .DEPTH(128), .RD_LATENCY(3)) ub (
      .clk(clk), .rst_n(rst_b_n), .bus(b)
`ifdef MEM_ACCESS_CNT_EN
      , .if_cnt(b_if_cnt), .d_cnt(b_d_cnt)
`endif
   );

   task automatic chk(input string n, input logic [15:0] act, input logic [15:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %h, expected %h", n, act, exp);
      end
   endtask

   task automatic mon(input int k, input logic v, input logic [7:0] d, input string n);
      exp_t e;
      if (q[k].size() != 0 && q[k][0].due < cyc) begin
         ntests++;
         nfail++;
         $display("FAIL %s: got no rvalid, expected data %h at cycle %0d", n, q[k][0].d, q[k][0].due);
         void'(q[k].pop_front());
      end
      if (v) begin
         ntests++;
         if (q[k].size() == 0) begin
            nfail++;
            $display("FAIL %s: got unexpected rvalid data %h at cycle %0d, expected none", n, d, cyc);
         end else begin
            e = q[k].pop_front();
            if (d !== e.d || cyc != e.due) begin
               nfail++;
               $display("FAIL %s: got data %h at cycle %0d, expected %h at cycle %0d", n, d, cyc, e.d, e.due);
            end
         end
      end
   endtask

   always @(negedge clk) begin
      mon(0, a.if_rvalid, a.if_rdata, "a_if_ret");
      mon(1, a.d_rvalid, a.d_rdata, "a_d_ret");
      mon(2, b.if_rvalid, b.if_rdata, "b_if_ret");
      mon(3, b.d_rvalid, b.d_rdata, "b_d_ret");
   end

   task automatic drv_a(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                        input logic [7:0] da, input logic [7:0] dd);
      a.if_req = ir; a.if_addr = ia; a.d_req = dr; a.d_we = dw; a.d_addr = da; a.d_wdata = dd;
   endtask

   task automatic drv_b(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                        input logic [7:0] da, input logic [7:0] dd);
      b.if_req = ir; b.if_addr = ia; b.d_req = dr; b.d_we = dw; b.d_addr = da; b.d_wdata = dd;
   endtask

   // one request cycle: drive, check grants, queue expected read return
   task automatic cyc_a(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                        input logic [7:0] da, input logic [7:0] dd,
                        input logic eig, input logic edg, input logic [7:0] ed);
      drv_a(ir, ia, dr, dw, da, dd);
      @(negedge clk);
      chk("a_if_gnt", a.if_gnt, eig);
      chk("a_d_gnt", a.d_gnt, edg);
      if (eig) q[0].push_back(exp_t'{ed, cyc + 1});
      if (edg && !dw) q[1].push_back(exp_t'{ed, cyc + 1});
      @(posedge clk); #1;
   endtask

   task automatic cyc_b(input logic ir, input logic [7:0] ia, input logic dr, input logic dw,
                        input logic [7:0] da, input logic [7:0] dd,
                        input logic eig, input logic edg, input logic [7:0] ed);
      drv_b(ir, ia, dr, dw, da, dd);
      @(negedge clk);
      chk("b_if_gnt", b.if_gnt, eig);
      chk("b_d_gnt", b.d_gnt, edg);
      if (eig) q[2].push_back(exp_t'{ed, cyc + 3});
      if (edg && !dw) q[3].push_back(exp_t'{ed, cyc + 3});
      @(posedge clk); #1;
   endtask

   task automatic run_a();
      drv_a(1, 8'h10, 1, 0, 8'h10, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("a_rst_if_gnt", a.if_gnt, 0);
      chk("a_rst_d_gnt", a.d_gnt, 0);
      chk("a_rst_busy", a.busy, 0);
      chk("a_rst_if_rdata", a.if_rdata, 0);
      chk("a_rst_d_rdata", a.d_rdata, 0);
      @(posedge clk); #1;
      rst_a_n = 1'b1;
      cyc_a(1, 8'h30, 1, 1, 8'h30, 8'h11, 0, 1, 8'h00);
      cyc_a(1, 8'h30, 1, 1, 8'h31, 8'h22, 1, 0, 8'h11);
      cyc_a(1, 8'h31, 1, 1, 8'h31, 8'h22, 0, 1, 8'h00);
      cyc_a(1, 8'h31, 1, 0, 8'h30, 8'h00, 1, 0, 8'h22);
      cyc_a(0, 8'h31, 1, 0, 8'h30, 8'h00, 0, 1, 8'h11);
      cyc_a(1, 8'h31, 1, 0, 8'h31, 8'h00, 0, 1, 8'h22);
      cyc_a(1, 8'h31, 0, 0, 8'h00, 8'h00, 1, 0, 8'h22);
      cyc_a(0, 8'h00, 1, 1, 8'h20, 8'h5A, 0, 1, 8'h00);
      cyc_a(0, 8'h00, 1, 0, 8'h20, 8'h00, 0, 1, 8'h5A);
      drv_a(0, 8'h00, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      chk("a_busy_load", a.busy, 1);
      chk("a_idle_if_gnt", a.if_gnt, 0);
      chk("a_idle_d_gnt", a.d_gnt, 0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("a_d_rdata_hold", a.d_rdata, 8'h5A);
      chk("a_if_rdata_hold", a.if_rdata, 8'h22);
      chk("a_busy_idle", a.busy, 0);
`ifdef MEM_ACCESS_CNT_EN
      rst_a_n = 1'b0;
      @(posedge clk); #1;
      chk("a_if_cnt_rst", a_if_cnt, 16'h0000);
      chk("a_d_cnt_rst", a_d_cnt, 16'h0000);
      rst_a_n = 1'b1;
      repeat (100) cyc_a(1, 8'h20, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5A);
      chk("a_if_cnt_100", a_if_cnt, 16'd100);
      repeat (69900) cyc_a(1, 8'h20, 0, 0, 8'h00, 8'h00, 1, 0, 8'h5A);
      chk("a_if_cnt_sat", a_if_cnt, 16'hFFFF);
      chk("a_d_cnt_zero", a_d_cnt, 16'h0000);
      drv_a(0, 8'h00, 0, 0, 8'h00, 8'h00);
`endif
   endtask

   task automatic run_b();
      drv_b(0, 8'h00, 0, 0, 8'h00, 8'h00);
      repeat (2) @(posedge clk);
      #1;
      rst_b_n = 1'b1;
      for (int k = 0; k < 4; k++) cyc_b(0, 8'h00, 1, 1, 8'(k), 8'(8'hA0 + k), 0, 1, 8'h00);
      cyc_b(0, 8'h00, 1, 1, 8'h10, 8'hB0, 0, 1, 8'h00);
      for (int k = 0; k < 4; k++) cyc_b(1, 8'(k), 0, 0, 8'h00, 8'h00, 1, 0, 8'(8'hA0 + k));
      cyc_b(0, 8'h00, 1, 1, 8'h80, 8'h77, 0, 1, 8'h00);
      cyc_b(0, 8'h00, 1, 0, 8'h80, 8'h00, 0, 1, 8'h00);
      cyc_b(0, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1, 8'hA0);
      repeat (5) cyc_b(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
      chk("b_if_rdata_hold", b.if_rdata, 8'hA3);
      // fetch of 0x10 is granted, then reset lands while it is still in flight
      drv_b(1, 8'h10, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      chk("b_mid_if_gnt", b.if_gnt, 1);
      @(posedge clk); #1;
      drv_b(0, 8'h00, 0, 0, 8'h00, 8'h00);
      @(negedge clk);
      chk("b_busy_inflight", b.busy, 1);
      #1 rst_b_n = 1'b0;
      #1;
      chk("b_rst_busy", b.busy, 0);
      chk("b_rst_if_rdata", b.if_rdata, 0);
      chk("b_rst_d_rdata", b.d_rdata, 0);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("b_rst_if_rvalid", b.if_rvalid, 0);
         chk("b_rst_busy_hold", b.busy, 0);
      end
      @(posedge clk); #1;
      rst_b_n = 1'b1;
      repeat (5) cyc_b(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
      chk("b_post_rst_if_rdata", b.if_rdata, 0);
      cyc_b(1, 8'h01, 1, 0, 8'h02, 8'h00, 0, 1, 8'hA2);
      cyc_b(1, 8'h01, 0, 0, 8'h00, 8'h00, 1, 0, 8'hA1);
      repeat (5) cyc_b(0, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
   endtask

   initial begin
      drv_a(0, 8'h00, 0, 0, 8'h00, 8'h00);
      drv_b(0, 8'h00, 0, 0, 8'h00, 8'h00);
      fork
         run_a();
         run_b();
      join
      repeat (4) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) chk("drain", 16'(q[k].size()), 16'h0000);
      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: got no end of stimulus, expected completion within 5 ms");
      $fatal(1, "timeout");
   end
endmodule
